// File: rtl/tgt_ccc_pkg.sv
// Shared types and CCC decode helpers for the target-side HDR-DDR CCC engine.
// Optional feature macro: TGT_CCC_GETSTATUS_EN.
// When it is defined, GETSTATUS (0x90) is decoded as a direct GET.
package tgt_ccc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CCC_VAL = 3'd1,
        ST_DIR_CMD = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_IGNORE  = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam logic [7:0] SETMWL_B  = 8'h09;
    localparam logic [7:0] SETMRL_B  = 8'h0A;
    localparam logic [7:0] SETMWL_D  = 8'h89;
    localparam logic [7:0] SETMRL_D  = 8'h8A;
    localparam logic [7:0] GETMWL    = 8'h8B;
    localparam logic [7:0] GETMRL    = 8'h8C;
    localparam logic [7:0] GETSTATUS = 8'h90;

    // Direct GET codes: answered by sourcing one response word.
    function automatic logic ccc_is_get(input logic [7:0] ccc);
        logic res;
        res = (ccc == GETMWL) || (ccc == GETMRL);
`ifdef TGT_CCC_GETSTATUS_EN
        res = res || (ccc == GETSTATUS);
`endif
        return res;
    endfunction

    // Direct codes are followed by per-target addressed command words.
    function automatic logic ccc_is_direct(input logic [7:0] ccc);
        return (ccc == SETMWL_D) || (ccc == SETMRL_D) || ccc_is_get(ccc);
    endfunction

    function automatic logic ccc_supported(input logic [7:0] ccc);
        return (ccc == SETMWL_B) || (ccc == SETMRL_B) || ccc_is_direct(ccc);
    endfunction

endpackage

// File: rtl/tgt_ddr_ccc_responder.sv
// Target-side HDR-DDR CCC engine: decodes controller CCC frames, maintains
// the max write/read length registers and sources direct GET responses.
// Optional feature macro: TGT_CCC_GETSTATUS_EN (adds GETSTATUS, returns i_status).
module tgt_ddr_ccc_responder
    import tgt_ccc_pkg::*;
#(
    parameter logic [6:0]  CCC_CMD_CODE = 7'h7F,
    parameter logic [6:0]  BCAST_ADDR   = 7'h7E,
    parameter logic [15:0] MWL_RST      = 16'h0100,
    parameter logic [15:0] MRL_RST      = 16'h0100
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_hdr_active,
    input  logic        i_rx_valid,
    input  logic        i_rx_is_cmd,
    input  logic [15:0] i_rx_word,
    input  logic        i_rx_par_err,
    input  logic        i_restart,
    input  logic        i_exit,
    input  logic [6:0]  i_dyn_addr,
    input  logic [15:0] i_status,
    output logic        o_tx_valid,
    output logic [15:0] o_tx_word,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic [15:0] o_mwl,
    output logic [15:0] o_mrl,
    output logic        o_mwl_upd,
    output logic        o_mrl_upd,
    output logic        o_ccc_err,
    output logic        o_busy
);

    state_t      state_reg, state_next;
    logic [7:0]  ccc_reg, ccc_next;
    logic [15:0] mwl_reg, mwl_next;
    logic [15:0] mrl_reg, mrl_next;
    logic [15:0] tx_word_reg, tx_word_next;
    logic        err_reg, err_next;
    logic        mwl_upd_reg, mwl_upd_next;
    logic        mrl_upd_reg, mrl_upd_next;
    logic [15:0] resp_word;

    // Command word fields.
    logic        cmd_rnw;
    logic [6:0]  cmd_code;
    logic [6:0]  cmd_addr;
    assign cmd_rnw  = i_rx_word[15];
    assign cmd_code = i_rx_word[14:8];
    assign cmd_addr = i_rx_word[7:1];

`ifndef TGT_CCC_GETSTATUS_EN
    logic unused_status;
    assign unused_status = ^i_status;
`endif

    // Response word for the latched GET code; captured when the GET is accepted
    // so the word stays stable while the serializer stalls.
    always_comb begin
        resp_word = 16'h0000;
        case (ccc_reg)
            GETMWL:    resp_word = mwl_reg;
            GETMRL:    resp_word = mrl_reg;
`ifdef TGT_CCC_GETSTATUS_EN
            GETSTATUS: resp_word = i_status;
`endif
            default:   resp_word = 16'h0000;
        endcase
    end

    // Next-state and register-file update logic, in event priority order.
    always_comb begin
        state_next   = state_reg;
        ccc_next     = ccc_reg;
        mwl_next     = mwl_reg;
        mrl_next     = mrl_reg;
        tx_word_next = tx_word_reg;
        err_next     = err_reg;
        mwl_upd_next = 1'b0;
        mrl_upd_next = 1'b0;

        if (!i_hdr_active) begin
            state_next = ST_IDLE;
            ccc_next   = 8'h00;
        end else if (i_exit) begin
            state_next = ST_IDLE;
            ccc_next   = 8'h00;
            err_next   = 1'b0;
        end else if (i_restart) begin
            // ERR is only left through exit or loss of HDR mode.
            if (state_reg != ST_ERR) begin
                if (ccc_is_direct(ccc_reg)) begin
                    state_next = ST_DIR_CMD;
                end else begin
                    state_next = ST_IDLE;
                    ccc_next   = 8'h00;
                end
            end
        end else begin
            if (state_reg == ST_RD_RESP && i_tx_ready) begin
                state_next = ST_IGNORE;
            end
            if (i_rx_valid) begin
                if (i_rx_par_err) begin
                    if (state_reg != ST_IDLE) begin
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (i_rx_is_cmd && !cmd_rnw && cmd_code == CCC_CMD_CODE &&
                                cmd_addr == BCAST_ADDR) begin
                                state_next = ST_CCC_VAL;
                            end
                        end
                        ST_CCC_VAL: begin
                            if (!i_rx_is_cmd) begin
                                ccc_next = i_rx_word[15:8];
                                if (i_rx_word[15:8] == SETMWL_B || i_rx_word[15:8] == SETMRL_B) begin
                                    state_next = ST_WR_DATA;
                                end else if (ccc_is_direct(i_rx_word[15:8])) begin
                                    state_next = ST_DIR_CMD;
                                end else begin
                                    state_next = ST_IGNORE;
                                end
                            end else begin
                                state_next = ST_IGNORE;
                            end
                        end
                        ST_DIR_CMD: begin
                            if (!i_rx_is_cmd) begin
                                state_next = ST_ERR;
                                err_next   = 1'b1;
                            end else if (cmd_addr != i_dyn_addr) begin
                                state_next = ST_IGNORE;
                            end else if (ccc_is_get(ccc_reg)) begin
                                if (cmd_rnw) begin
                                    state_next   = ST_RD_RESP;
                                    tx_word_next = resp_word;
                                end else begin
                                    state_next = ST_ERR;
                                    err_next   = 1'b1;
                                end
                            end else begin
                                if (!cmd_rnw) begin
                                    state_next = ST_WR_DATA;
                                end else begin
                                    state_next = ST_ERR;
                                    err_next   = 1'b1;
                                end
                            end
                        end
                        ST_WR_DATA: begin
                            state_next = ST_IGNORE;
                            if (!i_rx_is_cmd) begin
                                if (i_rx_word == 16'h0000) begin
                                    err_next = 1'b1;
                                end else if (ccc_reg == SETMWL_B || ccc_reg == SETMWL_D) begin
                                    mwl_next     = i_rx_word;
                                    mwl_upd_next = 1'b1;
                                end else begin
                                    mrl_next     = i_rx_word;
                                    mrl_upd_next = 1'b1;
                                end
                            end
                        end
                        default: begin
                            // RD_RESP, IGNORE and ERR drop incoming words.
                        end
                    endcase
                end
            end
        end
    end

    // State and register file.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_reg   <= ST_IDLE;
            ccc_reg     <= 8'h00;
            mwl_reg     <= MWL_RST;
            mrl_reg     <= MRL_RST;
            tx_word_reg <= 16'h0000;
            err_reg     <= 1'b0;
            mwl_upd_reg <= 1'b0;
            mrl_upd_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ccc_reg     <= ccc_next;
            mwl_reg     <= mwl_next;
            mrl_reg     <= mrl_next;
            tx_word_reg <= tx_word_next;
            err_reg     <= err_next;
            mwl_upd_reg <= mwl_upd_next;
            mrl_upd_reg <= mrl_upd_next;
        end
    end

    // The response is withdrawn in the same cycle HDR mode ends or exit arrives.
    assign o_tx_valid = (state_reg == ST_RD_RESP) && i_hdr_active && !i_exit;
    assign o_tx_word  = o_tx_valid ? tx_word_reg : 16'h0000;
    assign o_tx_last  = o_tx_valid;
    assign o_mwl      = mwl_reg;
    assign o_mrl      = mrl_reg;
    assign o_mwl_upd  = mwl_upd_reg;
    assign o_mrl_upd  = mrl_upd_reg;
    assign o_ccc_err  = err_reg;
    assign o_busy     = (state_reg != ST_IDLE);

endmodule
